seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
- Iterative signed multiply/divide unit sitting directly downstream of the register bank.
- Consumes the two register read operands (rs/rt data) and the destination register number.
- Returns a 32-bit result with a one-cycle write-enable pulse and destination tag for the register-bank write port.
- Uses one shared 32-step shift/add–subtract datapath, so MUL/MULH/DIV/REM are multi-cycle instead of widening the single-cycle ALU.

Parameters:
- WIDTH, 32, operand/result width; iteration count = WIDTH, total latency = WIDTH+2 cycles.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL (low word of signed product), 01 MULH (high word), 10 DIV (signed quotient), 11 REM (signed remainder)
- a  in  WIDTH  operand 1 (rs read data), signed
- b  in  WIDTH  operand 2 (rt read data), signed
- dest_in  in  5  destination register number, captured with operands
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result valid; used as register-bank write enable
- result  out  WIDTH  result, held until next accepted start
- dest_out  out  5  captured dest_in, held with result
- div_zero  out  1  set with done when DIV/REM had b==0; cleared on next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, dest_out=0, div_zero=0; internal counters/accumulators cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0 captures op, dest_in, |a|, |b|, sign(a), sign(b) and b==0.
  - Sets busy=1, done=0, div_zero=0. Goes to CALC with count=0.
  - start=0: stay in IDLE; done drops to 0 after one cycle.
- Operand magnitudes: two's-complement negate when negative, treated as unsigned WIDTH bits. |-2^31| = 0x80000000 unsigned.
- CALC: one iteration per cycle, exactly WIDTH cycles (edges E1..E32), then FIX.
  - MUL/MULH: 2*WIDTH-bit unsigned shift-add product of magnitudes.
  - DIV/REM: restoring division, WIDTH-bit quotient and remainder of magnitudes.
- FIX: one cycle; at edge E33 goes to IDLE and loads the sign-corrected result.
  - Product negated if sign(a)!=sign(b). MUL takes low WIDTH bits, MULH high WIDTH bits.
  - Quotient negated if sign(a)!=sign(b). Remainder negated if sign(a)=1; remainder sign follows the dividend, truncation toward zero.
  - Divide by zero (b==0): DIV result=all ones (-1); REM result=a unchanged; div_zero=1.
  - Overflow -2^31 / -1: DIV result=0x80000000, REM result=0. This falls out of magnitude arithmetic and must not be special-cased wrongly.
  - Same edge E33: done=1, busy=0, dest_out valid.
- Latency: done high in the cycle after edge E33, i.e. WIDTH+1 edges after the start-sampling edge.
- Back-to-back: done=1 for exactly one cycle. start may be asserted in that done cycle; it is accepted (state is IDLE), clearing done and div_zero at that edge.
- start while busy=1 is ignored and not queued. Operand/op/dest changes while busy have no effect.
- result/dest_out change only at FIX completion or reset.

Test Plan:
- MUL a=7, b=-3, dest_in=5, start one cycle -> busy for 33 cycles; done single pulse; result=0xFFFFFFEB (-21); dest_out=5; div_zero=0.
- MULH a=0x40000000, b=4 -> result=0x00000001. MULH a=-1, b=1 -> result=0xFFFFFFFF. MUL a=0x80000000, b=-1 -> result=0x80000000.
- DIV a=-7, b=2 -> result=0xFFFFFFFD (-3). REM a=-7, b=2 -> 0xFFFFFFFF (-1). REM a=7, b=-2 -> 1. DIV a=0x80000000, b=-1 -> 0x80000000; REM same operands -> 0.
- DIV a=5, b=0 -> result=0xFFFFFFFF, div_zero=1. REM a=5, b=0 -> result=5, div_zero=1. Next start with b=3 -> div_zero cleared at acceptance.
- Protocol: start held high during a busy operation -> ignored, one done only. Start asserted during done cycle -> second op accepted, its done exactly 34 cycles later.
- Async rst pulse mid-cycle at CALC iteration 10 -> busy/done/result/dest_out=0 immediately, no done. Subsequent MUL 6*7 -> result=42 with normal latency.

Source files
------------

// File: rtl/seq_mul_div.sv
// Iterative signed multiply/divide unit that feeds the register-bank write port.
// One shared shift/add-subtract datapath runs WIDTH steps, then one sign-fix step.
module seq_mul_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       dest_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       dest_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [1:0]       op_q;
  logic             neg_q;
  logic             sign_a_q;
  logic             bzero_q;
  logic [4:0]       dest_cap_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mag_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       dest_q;
  logic             div_zero_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   rem_signed;
  logic [WIDTH-1:0]   fix_result;

  // hi_q is the product high word / partial remainder; lo_q the multiplier / quotient.
  always_comb begin
    a_mag       = a[WIDTH-1] ? -a : a;
    b_mag       = b[WIDTH-1] ? -b : b;
    add_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    rem_shift   = {hi_q, lo_q[WIDTH-1]};
    rem_ge      = rem_shift >= {1'b0, mag_q};
    rem_diff    = rem_shift[WIDTH-1:0] - mag_q;
    prod        = {hi_q, lo_q};
    prod_signed = neg_q ? -prod : prod;
    quo_signed  = neg_q ? -lo_q : lo_q;
    rem_signed  = sign_a_q ? -hi_q : hi_q;
    fix_result  = '0;
    case (op_q)
      2'b00:   fix_result = prod_signed[WIDTH-1:0];
      2'b01:   fix_result = prod_signed[2*WIDTH-1:WIDTH];
      2'b10:   fix_result = bzero_q ? '1 : quo_signed;
      // A zero divisor accepts every trial subtract, so the remainder comes back as |a|.
      default: fix_result = rem_signed;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      bzero_q    <= 1'b0;
      dest_cap_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mag_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      dest_q     <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_CALC;
            count_q    <= '0;
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            op_q       <= op;
            dest_cap_q <= dest_in;
            neg_q      <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_a_q   <= a[WIDTH-1];
            bzero_q    <= (b == '0);
            hi_q       <= '0;
            if (op[1]) begin
              lo_q  <= a_mag;
              mag_q <= b_mag;
            end else begin
              lo_q  <= b_mag;
              mag_q <= a_mag;
            end
          end
        end
        S_CALC: begin
          if (op_q[1]) begin
            hi_q <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], rem_ge};
          end else begin
            hi_q <= add_sum[WIDTH:1];
            lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
          end
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q   <= fix_result;
          dest_q     <= dest_cap_q;
          div_zero_q <= op_q[1] & bzero_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign dest_out = dest_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed bench for seq_mul_div: arithmetic reference model plus literal expectations.
module tb_seq_mul_div;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  dest_in = '0;
  logic        busy, done, div_zero;
  logic [31:0] result;
  logic [4:0]  dest_out;

  int n_vec = 0;
  int n_fail = 0;

  seq_mul_div #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .dest_in(dest_in), .busy(busy), .done(done), .result(result),
    .dest_out(dest_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: returns {div_zero, result} from plain 64-bit signed math.
  function automatic logic [32:0] model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    r  = 0;
    case (o)
      2'b00: begin p = sx * sy; return {1'b0, p[31:0]}; end
      2'b01: begin p = sx * sy; return {1'b0, p[63:32]}; end
      2'b10: begin
        if (y == 0) return {1'b1, 32'hFFFF_FFFF};
        r = sx / sy;
        return {1'b0, r[31:0]};
      end
      default: begin
        if (y == 0) return {1'b1, x};
        r = sx % sy;
        return {1'b0, r[31:0]};
      end
    endcase
  endfunction

  // Protocol model: an accepted request completes WIDTH+1 edges later.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [31:0] m_result = '0, p_result = '0;
  logic [4:0]  m_dest = '0, p_dest = '0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_result <= '0; m_dest <= '0; m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_result <= p_result; m_dest <= p_dest; m_dz <= p_dz;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= WIDTH + 1;
        m_dz   <= 1'b0;
        {p_dz, p_result} <= model_op(op, a, b);
        p_dest <= dest_in;
      end
    end
  end

  always @(negedge clk) begin
    n_vec++;
    if ({busy, done, div_zero, dest_out, result} !== {m_busy, m_done, m_dz, m_dest, m_result}) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL cycle_model t=%0t: got busy=%b done=%b dz=%b dest=%0d result=%h, expected busy=%b done=%b dz=%b dest=%0d result=%h",
                 $time, busy, done, div_zero, dest_out, result, m_busy, m_done, m_dz, m_dest, m_result);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operation; b2b=1 issues it in the current (done) cycle of the previous one.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] d, input logic [31:0] er, input logic edz, input bit b2b);
    int lat;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = o; a = x; b = y; dest_in = d;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = y + 32'd1; dest_in = ~d;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("div_zero_cleared", {31'b0, div_zero}, 32'd0);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd33);
    chk("result", result, er);
    chk("dest_out", {27'b0, dest_out}, {27'b0, d});
    chk("div_zero", {31'b0, div_zero}, {31'b0, edz});
    chk("model_vs_literal", m_result, er);
    $display("op=%0d a=%h b=%h dest=%0d -> result=%h div_zero=%b latency=%0d%s",
             o, x, y, d, result, div_zero, lat, b2b ? " (back-to-back)" : "");
  endtask

  initial begin
    int dones;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dest", {27'b0, dest_out}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;

    run_op(2'b00, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op(2'b01, 32'h4000_0000, 32'd4,         5'd6,  32'h0000_0001, 1'b0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1,         5'd7,  32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1'b0, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'h0000_0001, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1'b0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1'b0, 1'b0);
    run_op(2'b10, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0,         5'd16, 32'hFFFF_FFFB, 1'b1, 1'b0);
    run_op(2'b11, 32'd5,         32'd0,         5'd17, 32'h0000_0005, 1'b1, 1'b0);
    run_op(2'b10, 32'd9,         32'd3,         5'd18, 32'h0000_0003, 1'b0, 1'b1);
    run_op(2'b10, 32'd100,       32'hFFFF_FFF9, 5'd19, 32'hFFFF_FFF2, 1'b0, 1'b1);

    // start held high through most of an operation must yield a single completion
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5; dest_in = 5'd9;
    repeat (20) begin @(posedge clk); #1; end
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("held_start_done_count", 32'(dones), 32'd1);
    chk("held_start_result", result, 32'd15);
    $display("op=0 a=00000003 b=00000005 dest=9 start held -> result=%h dones=%0d", result, dones);

    // asynchronous reset in the middle of CALC aborts the operation
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd200; dest_in = 5'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_dest", {27'b0, dest_out}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    $display("reset during CALC iteration 10 -> dones afterwards=%0d", dones);

    run_op(2'b00, 32'd6, 32'd7, 5'd3, 32'd42, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
